// File: rtl/divisor_seq_erro_pkg.sv
// ============================================================================
// Module  : divisor_seq_erro_pkg
// Brief   : Shared ALU opcode table and divider FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package divisor_seq_erro_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/divisor_seq_erro_div_passo.sv
// ============================================================================
// Module  : div_passo
// Brief   : One combinational restoring-division step on magnitudes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_passo #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             q_bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH:0]   w_diff;

   // The shifted remainder is below 2*divisor, so WIDTH+1 bits hold the difference.
   assign w_shift = {rem_in, q_bit_in};
   assign q_bit   = (w_shift >= {2'b00, divisor});
   assign w_diff  = w_shift[WIDTH:0] - {1'b0, divisor};
   assign rem_out = q_bit ? w_diff : w_shift[WIDTH:0];

endmodule

`default_nettype wire

// File: rtl/divisor_seq_erro.sv
// ============================================================================
// Module  : divisor_seq_erro
// Brief   : Multi-cycle restoring divider with per-operation and sticky error flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_seq_erro
   import divisor_seq_erro_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   input  logic             clr_erro,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quociente,
   output logic [WIDTH-1:0] resto,
   output logic             erro,
   output logic             ovf,
   output logic             erro_sticky
);

   localparam int               c_cw       = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [c_cw-1:0]  c_cnt_init = c_cw'(WIDTH);
   localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(1);

   state_t           r_state, w_next;
   logic [c_cw-1:0]  r_cnt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo, r_dvs;
   logic             r_neg_q, r_neg_r;
   logic [WIDTH-1:0] r_quociente, r_resto;
   logic             r_erro, r_ovf, r_sticky;

   logic             w_accept, w_dz, w_ovf, w_sa, w_sb, w_last, w_qbit;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quo_nx;
   logic [WIDTH:0]   w_rem_nx;

   assign w_accept = (r_state == ST_IDLE) && start && (sel == OP_DIV);
   assign w_dz     = (divisor == '0);
   assign w_ovf    = SIGNED && (dividendo == c_min) && (divisor == '1);
   assign w_sa     = SIGNED && dividendo[WIDTH-1];
   assign w_sb     = SIGNED && divisor[WIDTH-1];
   // Magnitude of MIN is 2^(WIDTH-1), still representable unsigned.
   assign w_mag_a  = w_sa ? -dividendo : dividendo;
   assign w_mag_b  = w_sb ? -divisor : divisor;
   assign w_last   = (r_cnt == c_cnt_last);
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};

   div_passo #(.WIDTH(WIDTH)) u_passo (
      .rem_in   (r_rem),
      .q_bit_in (r_quo[WIDTH-1]),
      .divisor  (r_dvs),
      .rem_out  (w_rem_nx),
      .q_bit    (w_qbit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (w_dz || w_ovf) ? ST_DONE : ST_CALC;
         ST_CALC: begin
            busy = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // The last restoring step and the sign correction share the DONE-entry edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quociente <= '0;
         r_resto     <= '0;
         r_erro      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_accept) begin
         r_erro <= w_dz;
         r_ovf  <= w_ovf && !w_dz;
         if (w_dz) begin
            r_quociente <= '1;
            r_resto     <= dividendo;
         end else if (w_ovf) begin
            r_quociente <= c_min;
            r_resto     <= '0;
         end else begin
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= c_cnt_init;
         end
      end else if (r_state == ST_CALC) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= r_cnt - c_cnt_last;
         if (w_last) begin
            r_quociente <= r_neg_q ? -w_quo_nx : w_quo_nx;
            r_resto     <= r_neg_r ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];
         end
      end
   end

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_sticky <= 1'b0;
      else if (w_accept && (w_dz || w_ovf)) r_sticky <= 1'b1;
      else if (clr_erro)                  r_sticky <= 1'b0;
   end

   assign quociente   = r_quociente;
   assign resto       = r_resto;
   assign erro        = r_erro;
   assign ovf         = r_ovf;
   assign erro_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_divisor_seq_erro.sv
// ============================================================================
// Module  : tb_divisor_seq_erro
// Brief   : Self-checking bench; unsigned and signed 8-bit dividers side by side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divisor_seq_erro;
   import divisor_seq_erro_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start_u, start_s, clr_erro;
   logic [2:0] sel;
   logic [7:0] dividendo, divisor;

   logic       busy_u, done_u, erro_u, ovf_u, stk_u;
   logic       busy_s, done_s, erro_s, ovf_s, stk_s;
   logic [7:0] quo_u, res_u, quo_s, res_s;

   int         n_tests = 0;
   int         n_fail  = 0;

   int         lat_u, lat_s, n_u, n_s;
   logic [7:0] q_u, r_u, q_s, r_s;
   logic       e_u, o_u, e_s, o_s, b_u, b_s;

   always #5 clk = ~clk;

   divisor_seq_erro #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst), .start(start_u), .sel(sel),
      .dividendo(dividendo), .divisor(divisor), .clr_erro(clr_erro),
      .busy(busy_u), .done(done_u), .quociente(quo_u), .resto(res_u),
      .erro(erro_u), .ovf(ovf_u), .erro_sticky(stk_u)
   );

   divisor_seq_erro #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .sel(sel),
      .dividendo(dividendo), .divisor(divisor), .clr_erro(clr_erro),
      .busy(busy_s), .done(done_s), .quociente(quo_s), .resto(res_s),
      .erro(erro_s), .ovf(ovf_s), .erro_sticky(stk_s)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left #1 after a rising edge; done is tracked for 14 cycles.
   task automatic run_both(input logic [7:0] a, input logic [7:0] b, input bit glitch);
      dividendo = a;
      divisor   = b;
      sel       = OP_DIV;
      start_u   = 1'b1;
      start_s   = 1'b1;
      @(posedge clk); #1;
      start_u = 1'b0;
      start_s = 1'b0;
      lat_u = 0; lat_s = 0; n_u = 0; n_s = 0;
      b_u = busy_u; b_s = busy_s;
      for (int k = 1; k <= 14; k++) begin
         if (done_u) begin
            n_u++;
            if (lat_u == 0) begin
               lat_u = k; q_u = quo_u; r_u = res_u; e_u = erro_u; o_u = ovf_u;
            end
         end
         if (done_s) begin
            n_s++;
            if (lat_s == 0) begin
               lat_s = k; q_s = quo_s; r_s = res_s; e_s = erro_s; o_s = ovf_s;
            end
         end
         if (glitch && k == 3) begin
            dividendo = 8'd10; divisor = 8'd2; start_u = 1'b1; start_s = 1'b1;
         end else begin
            dividendo = a; divisor = b; start_u = 1'b0; start_s = 1'b0;
         end
         if (k < 14) begin
            @(posedge clk); #1;
         end
      end
   endtask

   function automatic logic [33:0] model(input logic [7:0] a, input logic [7:0] b, input bit s);
      int ia, ib, q, r, lat;
      logic [7:0] qq, rr;
      logic e, o;
      e = 1'b0; o = 1'b0; lat = 9;
      if (b == 8'd0) begin
         e = 1'b1; qq = 8'hFF; rr = a; lat = 1;
      end else if (s && a == 8'h80 && b == 8'hFF) begin
         o = 1'b1; qq = 8'h80; rr = 8'h00; lat = 1;
      end else begin
         if (s) begin
            ia = int'($signed(a)); ib = int'($signed(b));
         end else begin
            ia = int'(a); ib = int'(b);
         end
         q = ia / ib;
         r = ia % ib;
         qq = q[7:0];
         rr = r[7:0];
      end
      return {lat[7:0], 8'd1, qq, rr, e, o};
   endfunction

   task automatic sweep_one(input logic [7:0] a, input logic [7:0] b);
      run_both(a, b, 1'b0);
      check_eq($sformatf("sweep_u %0d/%0d", a, b),
               {lat_u[7:0], n_u[7:0], q_u, r_u, e_u, o_u}, model(a, b, 1'b0));
      check_eq($sformatf("sweep_s %0d/%0d", a, b),
               {lat_s[7:0], n_s[7:0], q_s, r_s, e_s, o_s}, model(a, b, 1'b1));
   endtask

   initial begin
      int seen;
      logic [7:0] sa [8];
      logic [7:0] sb [8];
      sa = '{8'd77, 8'd0,  8'd5,   8'd255, 8'd0, 8'd128, 8'd128, 8'd200};
      sb = '{8'd1,  8'd13, 8'd200, 8'd255, 8'd0, 8'd1,   8'd255, 8'd255};

      rst = 1'b1; start_u = 1'b0; start_s = 1'b0; clr_erro = 1'b0;
      sel = 3'b000; dividendo = 8'd0; divisor = 8'd0;
      #1;
      check_eq("reset_u", {busy_u, done_u, quo_u, res_u, erro_u, ovf_u, stk_u}, 64'd0);
      check_eq("reset_s", {busy_s, done_s, quo_s, res_s, erro_s, ovf_s, stk_s}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // 200/7: unsigned 28 r4; signed -56/7 = -8 r0
      run_both(8'd200, 8'd7, 1'b0);
      check_eq("t1_lat_u", lat_u, 9);
      check_eq("t1_busy_u", b_u, 1'b1);
      check_eq("t1_res_u", {q_u, r_u, e_u, o_u}, {8'd28, 8'd4, 1'b0, 1'b0});
      check_eq("t1_res_s", {q_s, r_s, e_s, o_s}, {8'hF8, 8'h00, 1'b0, 1'b0});

      run_both(8'd55, 8'd0, 1'b0);
      check_eq("t2_lat_u", lat_u, 1);
      check_eq("t2_res_u", {q_u, r_u, e_u, o_u}, {8'hFF, 8'd55, 1'b1, 1'b0});
      check_eq("t2_res_s", {q_s, r_s, e_s, o_s}, {8'hFF, 8'd55, 1'b1, 1'b0});
      check_eq("t2_stk_u", stk_u, 1'b1);
      run_both(8'd9, 8'd3, 1'b0);
      check_eq("t2b_res_u", {q_u, r_u, e_u, o_u}, {8'd3, 8'd0, 1'b0, 1'b0});
      check_eq("t2b_stk_u", stk_u, 1'b1);
      clr_erro = 1'b1;
      @(posedge clk); #1;
      clr_erro = 1'b0;
      check_eq("t2_clr_stk", {stk_u, stk_s}, 2'b00);

      // -100/7: signed -14 r -2; unsigned 156/7 = 22 r2
      run_both(8'h9C, 8'd7, 1'b0);
      check_eq("t3_res_s", {q_s, r_s, e_s, o_s}, {8'hF2, 8'hFE, 1'b0, 1'b0});
      check_eq("t3_res_u", {q_u, r_u}, {8'd22, 8'd2});
      run_both(8'h80, 8'hFF, 1'b0);
      check_eq("t3_ovf_lat_s", lat_s, 1);
      check_eq("t3_ovf_s", {q_s, r_s, e_s, o_s, stk_s}, {8'h80, 8'h00, 1'b0, 1'b1, 1'b1});
      check_eq("t3_ovf_u", {lat_u[7:0], q_u, r_u, o_u, stk_u}, {8'd9, 8'd0, 8'd128, 1'b0, 1'b0});

      sel = 3'b010; start_u = 1'b1; start_s = 1'b1; dividendo = 8'd20; divisor = 8'd4;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (busy_u || done_u || busy_s || done_s) seen++;
      end
      start_u = 1'b0; start_s = 1'b0;
      check_eq("t4_badsel", seen, 0);

      run_both(8'd200, 8'd7, 1'b1);
      check_eq("t4_glitch_u", {n_u[7:0], q_u, r_u}, {8'd1, 8'd28, 8'd4});
      check_eq("t4_glitch_s", {n_s[7:0], q_s, r_s}, {8'd1, 8'hF8, 8'h00});
      check_eq("t4_idle_after", {busy_u, busy_s}, 2'b00);

      // reset in the middle of a computation, with the signed sticky flag set
      dividendo = 8'd200; divisor = 8'd7; sel = OP_DIV; start_u = 1'b1; start_s = 1'b1;
      @(posedge clk); #1;
      start_u = 1'b0; start_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("t5_rst_u", {busy_u, done_u, quo_u, res_u, erro_u, ovf_u, stk_u}, 64'd0);
      check_eq("t5_rst_s", {busy_s, done_s, quo_s, res_s, erro_s, ovf_s, stk_s}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done_u || done_s) seen++;
      end
      check_eq("t5_no_done", seen, 0);
      run_both(8'd100, 8'd10, 1'b0);
      check_eq("t5_after_u", {lat_u[7:0], q_u, r_u}, {8'd9, 8'd10, 8'd0});
      check_eq("t5_after_s", {lat_s[7:0], q_s, r_s}, {8'd9, 8'd10, 8'd0});

      for (int i = 0; i < 8; i++) sweep_one(sa[i], sb[i]);
      for (int i = 0; i < 2400; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         sweep_one(ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
